// File: rtl/cache_mgmt_unit.sv
// Cache management unit: direct-mapped, write-back, write-allocate data cache controller.
// Hits complete in the lookup cycle. Misses stall the CPU, write back a dirty victim word by word,
// then refill the line from memory over a cs/we/ack handshake.
module cache_mgmt_unit #(
  parameter int unsigned ADDR_BITS        = 32,
  parameter int unsigned WORD_BITS        = 32,
  parameter int unsigned WORD_BYTES_WIDTH = 2,
  parameter int unsigned LINE_WORDS_WIDTH = 2,
  parameter int unsigned LINE_NUM         = 64,
  localparam int unsigned INDEX_BITS      = $clog2(LINE_NUM),
  localparam int unsigned TAG_BITS        = ADDR_BITS - INDEX_BITS - LINE_WORDS_WIDTH - WORD_BYTES_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  // CPU side
  input  logic                 en_r,
  input  logic                 en_w,
  input  logic [ADDR_BITS-1:0] addr_rw,
  input  logic [WORD_BITS-1:0] data_w,
  output logic [WORD_BITS-1:0] data_r,
  output logic                 stall,
  // cache array side
  output logic [ADDR_BITS-1:0] cache_addr,
  output logic                 cache_store,
  output logic                 cache_edit,
  output logic [WORD_BITS-1:0] cache_din,
  input  logic                 cache_hit,
  input  logic                 cache_valid,
  input  logic                 cache_dirty,
  input  logic [TAG_BITS-1:0]  cache_tag,
  input  logic [WORD_BITS-1:0] cache_dout,
  // memory side
  output logic                 mem_cs_o,
  output logic                 mem_we_o,
  output logic [ADDR_BITS-1:0] mem_addr_o,
  output logic [WORD_BITS-1:0] mem_data_o,
  input  logic [WORD_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);

  localparam int unsigned OFFSET_BITS = LINE_WORDS_WIDTH + WORD_BYTES_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BACK,
    S_FILL,
    S_WAIT
  } state_t;

  state_t                      state;
  logic [LINE_WORDS_WIDTH-1:0] wcnt;

  logic                        req;
  logic [TAG_BITS-1:0]         req_tag;
  logic [INDEX_BITS-1:0]       req_index;
  logic [ADDR_BITS-1:0]        req_word_addr;
  logic [ADDR_BITS-1:0]        victim_word_addr;
  logic                        word_last;

  // Decode the CPU request and form the per-word line addresses for the burst.
  always_comb begin
    req              = en_r | en_w;
    req_tag          = addr_rw[ADDR_BITS-1 -: TAG_BITS];
    req_index        = addr_rw[OFFSET_BITS +: INDEX_BITS];
    req_word_addr    = {req_tag, req_index, wcnt, {WORD_BYTES_WIDTH{1'b0}}};
    victim_word_addr = {cache_tag, req_index, wcnt, {WORD_BYTES_WIDTH{1'b0}}};
    word_last        = (wcnt == {LINE_WORDS_WIDTH{1'b1}});
  end

  // Miss-handling sequencer; word counter advances only on a memory ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      wcnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req && !cache_hit) begin
            state <= (cache_valid && cache_dirty) ? S_BACK : S_FILL;
            wcnt  <= '0;
          end
        end
        S_BACK: begin
          if (mem_ack_i) begin
            wcnt <= wcnt + LINE_WORDS_WIDTH'(1);
            if (word_last) state <= S_FILL;
          end
        end
        S_FILL: begin
          if (mem_ack_i) begin
            wcnt <= wcnt + LINE_WORDS_WIDTH'(1);
            if (word_last) state <= S_WAIT;
          end
        end
        S_WAIT: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Array and memory strobes; all held constant within a state so memory sees stable requests.
  always_comb begin
    stall       = req & ~((state == S_IDLE) & cache_hit);
    data_r      = cache_dout;
    cache_addr  = addr_rw;
    cache_store = 1'b0;
    cache_edit  = 1'b0;
    cache_din   = data_w;
    mem_cs_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = req_word_addr;
    mem_data_o  = cache_dout;
    case (state)
      S_IDLE: cache_edit = en_w & cache_hit;
      S_BACK: begin
        cache_addr = req_word_addr;
        mem_cs_o   = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = victim_word_addr;
      end
      S_FILL: begin
        cache_addr  = req_word_addr;
        mem_cs_o    = 1'b1;
        cache_store = mem_ack_i;
        cache_din   = mem_data_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_mgmt_unit.sv
// Bench for cache_mgmt_unit: models the cache array and a variable-latency memory,
// and checks the controller against an architectural memory / line-state reference model.
module tb_cache_mgmt_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_r, en_w;
  logic [31:0] addr_rw, data_w, data_r;
  logic        stall;
  logic [31:0] cache_addr;
  logic        cache_store, cache_edit;
  logic [31:0] cache_din;
  logic        cache_hit, cache_valid, cache_dirty;
  logic [21:0] cache_tag;
  logic [31:0] cache_dout;
  logic        mem_cs_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
  logic        mem_ack_i;

  cache_mgmt_unit dut (
    .clk(clk), .rst(rst), .en_r(en_r), .en_w(en_w), .addr_rw(addr_rw), .data_w(data_w),
    .data_r(data_r), .stall(stall), .cache_addr(cache_addr), .cache_store(cache_store),
    .cache_edit(cache_edit), .cache_din(cache_din), .cache_hit(cache_hit),
    .cache_valid(cache_valid), .cache_dirty(cache_dirty), .cache_tag(cache_tag),
    .cache_dout(cache_dout), .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
    .mem_ack_i(mem_ack_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- main memory and architectural reference ----------------
  logic [31:0] mem     [int unsigned];
  logic [31:0] ref_mem [int unsigned];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  logic        ref_valid [64];
  logic        ref_dirty [64];
  logic [21:0] ref_tag   [64];
  logic [31:0] exp_rdata;
  int          exp_stall;
  int          lat_rd = 1;
  int          lat_wr = 1;

  // Reference: per request, predict memory traffic, stall length and load value.
  task automatic model_req(input logic [31:0] a, input logic st, input logic [31:0] d);
    int          idx;
    logic [21:0] tg;
    logic [31:0] va;
    idx = int'(a[9:4]);
    tg  = a[31:10];
    exp_stall = 0;
    if (!(ref_valid[idx] && ref_tag[idx] == tg)) begin
      exp_stall = 2 + 4 * lat_rd;
      if (ref_valid[idx] && ref_dirty[idx]) begin
        exp_stall += 4 * lat_wr;
        for (int w = 0; w < 4; w++) begin
          va = {ref_tag[idx], a[9:4], 4'h0} + 32'(w * 4);
          exp_q.push_back('{we: 1'b1, addr: va, data: ref_rd(va)});
        end
      end
      for (int w = 0; w < 4; w++) begin
        va = {a[31:4], 4'h0} + 32'(w * 4);
        exp_q.push_back('{we: 1'b0, addr: va, data: 32'h0});
      end
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = tg;
      ref_dirty[idx] = 1'b0;
    end
    if (st) begin
      ref_mem[a]     = d;
      ref_dirty[idx] = 1'b1;
    end else begin
      exp_rdata = ref_rd(a);
    end
  endtask

  // Reset drops every cached line; dirty data never reached memory, so it is lost.
  task automatic model_reset();
    logic [31:0] va;
    for (int i = 0; i < 64; i++) begin
      if (ref_valid[i] && ref_dirty[i]) begin
        for (int w = 0; w < 4; w++) begin
          va = {ref_tag[i], 6'(i), 4'h0} + 32'(w * 4);
          ref_mem[va] = mem_rd(va);
        end
      end
      ref_valid[i] = 1'b0;
      ref_dirty[i] = 1'b0;
      ref_tag[i]   = '0;
    end
  endtask

  // ---------------- cache array model ----------------
  logic [21:0] a_tag   [64];
  logic        a_valid [64];
  logic        a_dirty [64];
  logic [31:0] a_data  [64][4];
  logic [5:0]  ci;
  logic [1:0]  cw;
  int          edit_cnt = 0;

  always_comb begin
    ci          = cache_addr[9:4];
    cw          = cache_addr[3:2];
    cache_valid = a_valid[ci];
    cache_dirty = a_dirty[ci];
    cache_tag   = a_tag[ci];
    cache_hit   = a_valid[ci] && (a_tag[ci] == cache_addr[31:10]);
    cache_dout  = a_data[ci][cw];
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        a_valid[i] <= 1'b0;
        a_dirty[i] <= 1'b0;
      end
    end else if (cache_store) begin
      a_data[ci][cw] <= cache_din;
      a_valid[ci]    <= 1'b1;
      a_dirty[ci]    <= 1'b0;
      a_tag[ci]      <= cache_addr[31:10];
    end else if (cache_edit) begin
      a_data[ci][cw] <= cache_din;
      a_dirty[ci]    <= 1'b1;
      edit_cnt       <= edit_cnt + 1;
    end
  end

  // ---------------- memory responder ----------------
  int   cnt = 0;
  int   wr_acks = 0;
  int   rd_acks = 0;
  txn_t snap;
  txn_t e;

  initial begin
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack_i  = 1'b0;
      mem_data_i = $urandom;
      if (rst) begin
        cnt = 0;
      end else if (mem_cs_o) begin
        if (cnt == 0) begin
          snap.we   = mem_we_o;
          snap.addr = mem_addr_o;
          snap.data = mem_data_o;
        end else begin
          check("mem_addr_stable", mem_addr_o, snap.addr);
          check("mem_we_stable", 32'(mem_we_o), 32'(snap.we));
          if (snap.we) check("mem_data_stable", mem_data_o, snap.data);
        end
        cnt++;
        if (cnt >= (mem_we_o ? lat_wr : lat_rd)) begin
          cnt       = 0;
          mem_ack_i = 1'b1;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_mem_txn: got addr %h we %0d, want no transfer", mem_addr_o, mem_we_o);
          end else begin
            e = exp_q.pop_front();
            check("mem_we", 32'(mem_we_o), 32'(e.we));
            check("mem_addr", mem_addr_o, e.addr);
            if (e.we) check("wb_data", mem_data_o, e.data);
          end
          if (mem_we_o) begin
            mem[mem_addr_o] = mem_data_o;
            wr_acks++;
          end else begin
            mem_data_i = mem_rd(mem_addr_o);
            rd_acks++;
          end
        end
      end else if (cnt != 0) begin
        total++;
        bad++;
        $display("FAIL cs_dropped: got cs 0 before ack, want cs held");
        cnt = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic        cur_active = 1'b0;
  logic        cur_we;
  logic [31:0] cur_data;

  always @(negedge clk) begin
    if (cur_active && !stall) begin
      if (cur_we) begin
        check("edit_strobe", 32'(cache_edit), 32'd1);
        check("edit_din", cache_din, cur_data);
      end else begin
        check("load_data", data_r, exp_rdata);
      end
    end
    if (cache_edit) check("edit_while_stalled", 32'(stall), 32'd0);
    if (cache_store) check("store_without_fill_ack", 32'({mem_cs_o, mem_we_o, mem_ack_i}), 32'b101);
  end

  // ---------------- driver ----------------
  task automatic start_req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    model_req(a, w, d);
    en_r       = r;
    en_w       = w;
    addr_rw    = a;
    data_w     = d;
    cur_we     = w;
    cur_data   = d;
    cur_active = 1'b1;
  endtask

  task automatic wait_done(input string name, input int exp_st, output logic [31:0] got, output int stalls);
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      stalls++;
      if (stalls > 300) begin
        total++;
        bad++;
        $display("FAIL %s_timeout: got stall still high after %0d cycles, want release", name, stalls);
        break;
      end
    end
    got = data_r;
    if (exp_st >= 0) check({name, "_stall_cycles"}, 32'(stalls), 32'(exp_st));
    check({name, "_pending_txns"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #2;
    en_r       = 1'b0;
    en_w       = 1'b0;
    cur_active = 1'b0;
  endtask

  task automatic do_req(input string name, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] got, output int stalls);
    start_req(r, w, a, d);
    wait_done(name, exp_stall, got, stalls);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] a;
    int          st;
    int          base;
    int          guard;
    int          kind;

    rst     = 1'b1;
    en_r    = 1'b0;
    en_w    = 1'b0;
    addr_rw = '0;
    data_w  = '0;
    model_reset();
    for (int w = 0; w < 4; w++) begin
      mem[32'h100 + 32'(w * 4)]     = 32'hA0 + 32'(w);
      ref_mem[32'h100 + 32'(w * 4)] = 32'hA0 + 32'(w);
    end

    // reset state
    @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_cs", 32'(mem_cs_o), 32'd0);
    check("rst_we", 32'(mem_we_o), 32'd0);
    check("rst_strobes", 32'({cache_store, cache_edit}), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // cold load: clean line refill
    do_req("t1_cold_load", 1'b1, 1'b0, 32'h0000_0104, 32'h0, got, st);
    check("t1_data", got, 32'hA1);
    check("t1_stalls", 32'(st), 32'd6);
    check("t1_reads", 32'(rd_acks), 32'd4);

    // load hit, zero latency
    do_req("t2_hit", 1'b1, 1'b0, 32'h0000_0108, 32'h0, got, st);
    check("t2_data", got, 32'hA2);
    check("t2_stalls", 32'(st), 32'd0);
    check("t2_no_mem", 32'(rd_acks + wr_acks), 32'd4);

    // store hit, single edit
    do_req("t3_store_hit", 1'b0, 1'b1, 32'h0000_010C, 32'h0000_DEAD, got, st);
    check("t3_stalls", 32'(st), 32'd0);
    check("t3_edits", 32'(edit_cnt), 32'd1);

    // conflict miss on a dirty line: write-back then refill
    do_req("t4_conflict", 1'b1, 1'b0, 32'h0000_1104, 32'h0, got, st);
    check("t4_stalls", 32'(st), 32'd10);
    check("t4_writes", 32'(wr_acks), 32'd4);
    check("t4_mem_word3", mem_rd(32'h10C), 32'h0000_DEAD);
    check("t4_mem_word0", mem_rd(32'h100), 32'hA0);
    check("t4_data", got, init_val(32'h1104));

    // slow write-back acks
    do_req("t6_store", 1'b0, 1'b1, 32'h0000_1108, 32'h0000_BEEF, got, st);
    lat_wr = 3;
    do_req("t6_slow_back", 1'b1, 1'b0, 32'h0000_2104, 32'h0, got, st);
    check("t6_stalls", 32'(st), 32'd18);
    check("t6_writes", 32'(wr_acks), 32'd8);
    check("t6_mem_wb", mem_rd(32'h1108), 32'h0000_BEEF);
    lat_wr = 1;

    // reset in the middle of a refill
    base  = rd_acks;
    guard = 0;
    start_req(1'b1, 1'b0, 32'h0000_3104, 32'h0);
    while (rd_acks < base + 2 && guard < 100) begin
      @(posedge clk);
      #2;
      guard++;
    end
    if (guard >= 100) begin
      total++;
      bad++;
      $display("FAIL t5_fill_progress: got %0d reads, want 2", rd_acks - base);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    model_reset();
    model_req(32'h0000_3104, 1'b0, 32'h0);
    @(negedge clk);
    check("t5_cs_after_rst", 32'(mem_cs_o), 32'd0);
    check("t5_stall_after_rst", 32'(stall), 32'd1);
    base = rd_acks;
    wait_done("t5_restart", exp_stall - 1, got, st);
    check("t5_data", got, mem_rd(32'h3104));
    check("t5_refill_reads", 32'(rd_acks - base), 32'd4);

    // randomized traffic over a few conflicting lines
    for (int n = 0; n < 150; n++) begin
      lat_rd = $urandom_range(1, 3);
      lat_wr = $urandom_range(1, 3);
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4) |
          (32'($urandom_range(0, 3)) << 2);
      kind = $urandom_range(0, 3);
      case (kind)
        0, 1: do_req("rnd_load", 1'b1, 1'b0, a, 32'h0, got, st);
        2:    do_req("rnd_store", 1'b0, 1'b1, a, $urandom, got, st);
        default: do_req("rnd_both", 1'b1, 1'b1, a, $urandom, got, st);
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
